// File: rtl/bp_pkg.sv
// bp_pkg: definitions shared by the branch resolver and its in-flight FIFO.
//   DEPTH_DEF / CNT_W_DEF : default FIFO depth and statistics-counter width
//   occ_w()               : bit width needed to hold an occupancy of 0..depth
//   entry_t               : one in-flight branch {pending, pred}
package bp_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 16;

   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // pending = request issued, prediction not yet returned by the predictor
   typedef struct packed {
      logic pending;
      logic pred;
   } entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: program-ordered store of predicted, unresolved branches.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : allocate the tail slot as pending
//   pop        : retire the head slot
//   flush      : discard every entry (takes priority over all else)
//   pred_in    : predictor output, captured into the slot pushed last cycle
//   head_pred  : prediction of the head entry, bypassing pred_in while pending
//   capture    : a prediction is being captured this cycle
//   count      : current occupancy
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int OCC_W = occ_w(DEPTH),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic             pred_in,
   output logic             head_pred,
   output logic             capture,
   output logic [OCC_W-1:0] count
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] pend_ptr;
   logic             pend_flag;
   logic [DEPTH-1:0] pend_vec;
   logic [DEPTH-1:0] pred_vec;

   // Each slot is its own register so that flush can clear all pending
   // flags in one edge.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         entry_t slot;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               slot <= '0;
            end else if (flush) begin
               slot.pending <= 1'b0;
            end else if (push && (wr_ptr == PTR_W'(gi))) begin
               slot <= '{pending: 1'b1, pred: 1'b0};
            end else if (pend_flag && (pend_ptr == PTR_W'(gi))) begin
               slot <= '{pending: 1'b0, pred: pred_in};
            end
         end
         assign pend_vec[gi] = slot.pending;
         assign pred_vec[gi] = slot.pred;
      end
   endgenerate

   // A branch may be resolved in the very cycle its prediction arrives.
   assign head_pred = pend_vec[rd_ptr] ? pred_in : pred_vec[rd_ptr];
   assign capture   = pend_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pend_ptr  <= '0;
         pend_flag <= 1'b0;
         count     <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pend_flag <= 1'b0;
         count     <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            pend_ptr <= wr_ptr;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         pend_flag <= push;
         count     <= count + OCC_W'(push) - OCC_W'(pop);
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: requester-side partner of a 2-bit branch predictor.
//   fetch_branch / fetch_ready            : branch handshake from fetch
//   fetch_pred_valid / fetch_pred_taken   : prediction returned to fetch
//   pred_request / pred_prediction        : query to / answer from predictor
//   pred_result / pred_taken              : training update to predictor
//   ex_resolve / ex_taken                 : oldest branch resolved by execute
//   mispredict                            : registered one-cycle pulse
//   inflight                              : occupancy of the in-flight FIFO
//   resolved_cnt / mispredict_cnt         : saturating statistics
//   protocol_err                          : sticky, resolve with nothing in flight
module branch_resolver
   import bp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_branch,
   output logic                       fetch_ready,
   output logic                       fetch_pred_valid,
   output logic                       fetch_pred_taken,
   output logic                       pred_request,
   input  logic                       pred_prediction,
   output logic                       pred_result,
   output logic                       pred_taken,
   input  logic                       ex_resolve,
   input  logic                       ex_taken,
   output logic                       mispredict,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic [CNT_W-1:0]           resolved_cnt,
   output logic [CNT_W-1:0]           mispredict_cnt,
   output logic                       protocol_err
);

   localparam int OCC_W = occ_w(DEPTH);

   logic accept;
   logic resolve;
   logic mismatch;
   logic flush_now;
   logic head_pred;
   logic capture;

   bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .pop       (resolve),
      .flush     (flush_now),
      .pred_in   (pred_prediction),
      .head_pred (head_pred),
      .capture   (capture),
      .count     (inflight)
   );

   // Nothing is accepted in a flush cycle, so a new branch never lands in
   // a FIFO that is being discarded.
   assign flush_now   = mismatch;
   assign fetch_ready = (inflight < OCC_W'(DEPTH)) & ~flush_now;
   assign accept      = fetch_branch & fetch_ready;
   assign pred_request = accept;

   assign resolve     = ex_resolve & (inflight != '0);
   assign pred_result = resolve;
   assign pred_taken  = ex_taken;
   assign mismatch    = resolve & (ex_taken != head_pred);

   assign fetch_pred_valid = capture;
   assign fetch_pred_taken = pred_prediction;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict     <= 1'b0;
         resolved_cnt   <= '0;
         mispredict_cnt <= '0;
         protocol_err   <= 1'b0;
      end else begin
         mispredict <= mismatch;
         if (resolve && (resolved_cnt != '1)) begin
            resolved_cnt <= resolved_cnt + CNT_W'(1);
         end
         if (mismatch && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
         end
         if (ex_resolve && (inflight == '0)) begin
            protocol_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed plus random stimulus against a queue-based
// reference model and a behavioural 2-bit predictor.
module tb_branch_resolver;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             fetch_branch, fetch_ready, fetch_pred_valid, fetch_pred_taken;
   logic             pred_request, pred_prediction, pred_result, pred_taken;
   logic             ex_resolve, ex_taken, mispredict, protocol_err;
   logic [2:0]       inflight;
   logic [CNT_W-1:0] resolved_cnt, mispredict_cnt;

   branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_branch(fetch_branch), .fetch_ready(fetch_ready),
      .fetch_pred_valid(fetch_pred_valid), .fetch_pred_taken(fetch_pred_taken),
      .pred_request(pred_request), .pred_prediction(pred_prediction),
      .pred_result(pred_result), .pred_taken(pred_taken),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken),
      .mispredict(mispredict), .inflight(inflight),
      .resolved_cnt(resolved_cnt), .mispredict_cnt(mispredict_cnt),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: predictions of in-flight branches in program order.
   bit q[$];
   int ctr = 2;          // predictor 2-bit counter, weakly taken
   int rcnt = 0, mcnt = 0;
   bit perr = 0, exp_misp = 0;
   bit nv = 0, nval = 0; // prediction due to fetch this cycle

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      rcnt = 0; mcnt = 0; perr = 0; exp_misp = 0; nv = 0; nval = 0;
   endtask

   task automatic check_regs();
      chk("inflight", inflight, q.size());
      chk("mispredict", mispredict, exp_misp);
      chk("resolved_cnt", resolved_cnt, rcnt);
      chk("mispredict_cnt", mispredict_cnt, mcnt);
      chk("protocol_err", protocol_err, perr);
   endtask

   task automatic step(input bit fb, input bit er, input bit et);
      bit res, mis, rdy, acc, p, empty_res;
      @(negedge clk);
      fetch_branch = fb;
      ex_resolve   = er;
      ex_taken     = et;
      pred_prediction = nv ? nval : 1'($urandom);
      #1;
      res = er && (q.size() > 0);
      empty_res = er && (q.size() == 0);
      mis = res && (et != q[0]);
      rdy = (q.size() < DEPTH) && !mis;
      acc = fb && rdy;
      chk("fetch_ready", fetch_ready, rdy);
      chk("pred_request", pred_request, acc);
      chk("pred_result", pred_result, res);
      if (res) chk("pred_taken", pred_taken, et);
      chk("fetch_pred_valid", fetch_pred_valid, nv);
      if (nv) chk("fetch_pred_taken", fetch_pred_taken, nval);
      @(posedge clk);
      p = (ctr >= 2);
      if (res) begin
         void'(q.pop_front());
         if (rcnt < CNT_MAX) rcnt++;
         ctr = et ? ((ctr < 3) ? ctr + 1 : 3) : ((ctr > 0) ? ctr - 1 : 0);
      end
      if (mis) begin
         q.delete();
         if (mcnt < CNT_MAX) mcnt++;
      end
      if (acc) q.push_back(p);
      if (empty_res) perr = 1;
      nv = acc; nval = p; exp_misp = mis;
      #1;
      check_regs();
   endtask

   initial begin
      rst_n = 1'b0;
      fetch_branch = 1'b0; ex_resolve = 1'b0; ex_taken = 1'b0; pred_prediction = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset fetch_ready", fetch_ready, 1);
      chk("reset fetch_pred_valid", fetch_pred_valid, 0);
      check_regs();
      @(negedge clk);
      rst_n = 1'b1;

      // single branch, resolved taken
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 1, 1);

      // mispredict flush with a refused fetch in the resolve cycle
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
      step(1, 1, !q[0]);
      step(0, 0, 0);

      // fill to DEPTH, refuse the fifth, resolve while full, refill
      repeat (4) step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, q[0]);
      step(1, 0, 0);
      while (q.size() > 0) step(0, 1, q[0]);

      // resolve in the cycle after accept, opposite direction
      step(1, 0, 0);
      step(0, 1, !q[0]);
      step(0, 0, 0);

      // train towards not-taken
      step(1, 0, 0); step(0, 1, 0);
      step(1, 0, 0); step(0, 1, 0);
      step(1, 0, 0); step(0, 0, 0);
      step(0, 1, 0);

      // random traffic; counters saturate at CNT_MAX
      for (int i = 0; i < 400; i++) begin
         bit fb, er, et;
         fb = ($urandom_range(0, 99) < 60);
         er = (q.size() > 0) && ($urandom_range(0, 99) < 45);
         et = (q.size() > 0 && $urandom_range(0, 99) < 75) ? q[0] : 1'($urandom);
         step(fb, er, et);
      end
      while (q.size() > 0) step(0, 1, q[0]);

      // resolve with nothing in flight
      step(0, 1, 1);
      step(0, 0, 0);

      // asynchronous reset with two branches in flight
      step(1, 0, 0); step(1, 0, 0);
      @(negedge clk);
      fetch_branch = 1'b0; ex_resolve = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async reset fetch_pred_valid", fetch_pred_valid, 0);
      check_regs();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0);
      step(0, 1, q[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
